oqpsk_modulator: RTL and testbench

- Transmit-side counterpart of the IQ demodulator: converts a serial 802.15.4 chip stream into offset-QPSK half-sine-shaped I/Q sample pairs.
- Even chips (1st, 3rd, …) go to I and odd chips to Q. Q is delayed by one chip period Tc.
- Output samples are 5-bit offset-binary, code 16 = zero level, the same format the demodulator filter input accepts.
- Output uses a valid/ready (pret) handshake so it can feed the filter or DAC path directly.

---
 rtl/iq_mod_pkg.sv | 40 ++++
 rtl/half_sine_rom.sv | 28 ++
 rtl/oqpsk_modulator.sv | 171 +++++++++++++++++
 tb/tb_oqpsk_modulator.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_mod_pkg.sv
// Shared types and constants for the OQPSK transmit path.
// Latency: n/a (declarations and a constant function only).
// Backpressure: n/a.
package iq_mod_pkg;

    // 5-bit offset-binary sample; code 16 is the zero level.
    typedef logic [4:0] sample_t;

    localparam sample_t ZERO_LVL = 5'd16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        TAIL
    } state_t;

    // Magnitude of the half-sine pulse at position n:
    // round(amp * sin(pi * n / (2*spt))), for n = 0..2*spt-1.
    // The sine comes from a short Taylor series. The angle is first folded
    // into [0, pi/2], which keeps the truncation error far below half an LSB.
    function automatic int half_sine_mag(input int spt, input int amp, input int n);
        real pi_c;
        real x;
        real term;
        real acc;
        pi_c = 3.14159265358979323846;
        x    = pi_c * real'(n) / real'(2 * spt);
        if (x > pi_c / 2.0) begin
            x = pi_c - x;
        end
        acc  = x;
        term = x;
        for (int k = 1; k <= 6; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        return int'(real'(amp) * acc);
    endfunction

endpackage

// File: rtl/half_sine_rom.sv
// Half-sine pulse ROM: maps a pulse index and a chip polarity to an offset-binary sample.
// Latency: combinational.
// Backpressure: none; the caller holds index and chip stable while stalled.
// Ports: index (pulse position 0..2*SPT-1), chip (1 = positive pulse), sample (16 +/- LUT[index]).
module half_sine_rom
    import iq_mod_pkg::*;
#(
    parameter int SPT = 4,
    parameter int AMP = 15,
    parameter int IW  = $clog2(2 * SPT)
) (
    input  logic [IW-1:0] index,
    input  logic          chip,
    output sample_t       sample
);

    logic [3:0] mag [2*SPT];

    // The table is fixed at elaboration, so each entry is a constant.
    for (genvar g = 0; g < 2 * SPT; g++) begin : g_lut
        localparam int M = half_sine_mag(SPT, AMP, g);
        assign mag[g] = 4'(M);
    end

    assign sample = chip ? (ZERO_LVL + {1'b0, mag[index]})
                         : (ZERO_LVL - {1'b0, mag[index]});

endmodule

// File: rtl/oqpsk_modulator.sv
// OQPSK modulator: serial chips -> half-sine shaped I/Q sample pairs, with Q offset by one chip.
// Latency: first sample valid one clock after the first chip is accepted; N chips -> (N+1)*SPT samples.
// Backpressure: a sample advances only on out_valid && pret; chips are taken through a one-entry buffer (chip_ready).
// Ports: clk, resetn (async active-low); chip_in/chip_valid/chip_last/chip_ready (chip input);
//        i_out/q_out/out_valid/pret (sample output); busy (burst active), underrun (sticky missing-chip flag).
module oqpsk_modulator
    import iq_mod_pkg::*;
#(
    parameter int SPT = 4,
    parameter int AMP = 15,
    parameter int W   = 5
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         chip_in,
    input  logic         chip_valid,
    input  logic         chip_last,
    output logic         chip_ready,
    output logic [W-1:0] i_out,
    output logic [W-1:0] q_out,
    output logic         out_valid,
    input  logic         pret,
    output logic         busy,
    output logic         underrun
);

    localparam int            PN      = 2 * SPT;
    localparam int            PW      = $clog2(PN);
    localparam logic [PW-1:0] PH_LAST = PW'(PN - 1);
    localparam logic [PW-1:0] PH_Q    = PW'(SPT);

    state_t        state;
    logic [PW-1:0] phase;
    logic [PW-1:0] next_phase;
    logic [PW-1:0] q_idx;
    logic          adv;
    logic          i_bnd;
    logic          q_bnd;
    logic          tail_done;

    // One-entry chip buffer.
    logic          buf_full;
    logic          buf_chip;
    logic          buf_last;

    // Per-rail pulse state. A rail that is not active outputs the zero level.
    logic          i_chip;
    logic          i_act;
    logic          q_chip;
    logic          q_act;
    // Marks which rail took the last chip. The burst ends when the phase
    // returns to that rail's boundary, which is one full pulse after the load.
    logic          last_on_q;

    sample_t       i_smp;
    sample_t       q_smp;

    assign adv        = out_valid && pret;
    assign next_phase = (phase == PH_LAST) ? '0 : phase + PW'(1);
    assign i_bnd      = (next_phase == '0);
    assign q_bnd      = (next_phase == PH_Q);
    assign q_idx      = (phase >= PH_Q) ? phase - PH_Q : phase + PH_Q;
    assign tail_done  = (state == TAIL) && (last_on_q ? q_bnd : i_bnd);

    assign chip_ready = !buf_full && (state != TAIL);

    half_sine_rom #(.SPT(SPT), .AMP(AMP), .IW(PW)) u_rom_i (
        .index  (phase),
        .chip   (i_chip),
        .sample (i_smp)
    );

    half_sine_rom #(.SPT(SPT), .AMP(AMP), .IW(PW)) u_rom_q (
        .index  (q_idx),
        .chip   (q_chip),
        .sample (q_smp)
    );

    // The outputs decode registered state only. They hold while pret is low,
    // and they drop to the zero level as soon as reset is asserted.
    assign i_out = i_act ? i_smp : ZERO_LVL;
    assign q_out = q_act ? q_smp : ZERO_LVL;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            phase     <= '0;
            buf_full  <= 1'b0;
            buf_chip  <= 1'b0;
            buf_last  <= 1'b0;
            i_chip    <= 1'b0;
            i_act     <= 1'b0;
            q_chip    <= 1'b0;
            q_act     <= 1'b0;
            last_on_q <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (buf_full) begin
                        i_chip    <= buf_chip;
                        i_act     <= 1'b1;
                        q_act     <= 1'b0;
                        phase     <= '0;
                        buf_full  <= 1'b0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        underrun  <= 1'b0;
                        last_on_q <= 1'b0;
                        state     <= buf_last ? TAIL : RUN;
                    end
                end
                RUN, TAIL: begin
                    if (adv) begin
                        phase <= next_phase;
                        if (tail_done) begin
                            state     <= IDLE;
                            phase     <= '0;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            i_act     <= 1'b0;
                            q_act     <= 1'b0;
                        end else if (i_bnd) begin
                            if (state == TAIL) begin
                                i_act <= 1'b0;
                            end else if (buf_full) begin
                                i_chip   <= buf_chip;
                                i_act    <= 1'b1;
                                buf_full <= 1'b0;
                                if (buf_last) begin
                                    state     <= TAIL;
                                    last_on_q <= 1'b0;
                                end
                            end else begin
                                i_act    <= 1'b0;
                                underrun <= 1'b1;
                            end
                        end else if (q_bnd) begin
                            if (state == TAIL) begin
                                q_act <= 1'b0;
                            end else if (buf_full) begin
                                q_chip   <= buf_chip;
                                q_act    <= 1'b1;
                                buf_full <= 1'b0;
                                if (buf_last) begin
                                    state     <= TAIL;
                                    last_on_q <= 1'b1;
                                end
                            end else begin
                                q_act    <= 1'b0;
                                underrun <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // chip_ready is low whenever the buffer is full, so an accept
            // never coincides with the consume above.
            if (chip_valid && chip_ready) begin
                buf_full <= 1'b1;
                buf_chip <= chip_in;
                buf_last <= chip_last;
            end
        end
    end

endmodule

// File: tb/tb_oqpsk_modulator.sv
module tb_oqpsk_modulator;

    localparam int SPT = 4;
    localparam int AMP = 15;
    localparam int W   = 5;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         chip_in = 1'b0;
    logic         chip_valid = 1'b0;
    logic         chip_last = 1'b0;
    logic         pret = 1'b0;
    logic         chip_ready;
    logic         out_valid;
    logic         busy;
    logic         underrun;
    logic [W-1:0] i_out;
    logic [W-1:0] q_out;

    always #10 clk = ~clk;

    oqpsk_modulator #(.SPT(SPT), .AMP(AMP), .W(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .chip_in    (chip_in),
        .chip_valid (chip_valid),
        .chip_last  (chip_last),
        .chip_ready (chip_ready),
        .i_out      (i_out),
        .q_out      (q_out),
        .out_valid  (out_valid),
        .pret       (pret),
        .busy       (busy),
        .underrun   (underrun)
    );

    typedef struct {
        int         n;
        logic [7:0] bits;
        int         mode;
        int         exp_len;
        bit         use_ref;
    } case_t;

    int    n_checks = 0;
    int    n_fail = 0;
    int    lut [2*SPT];
    bit    chip_seq [64];
    int    obs_i [$];
    int    obs_q [$];
    int    ref_i [12];
    int    ref_q [12];
    case_t cases [5];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Reference: chip j drives rail (j % 2) with a 2*SPT-sample half-sine starting at sample j*SPT.
    function automatic int model_sample(input int s, input int n, input int rail);
        for (int j = rail; j < n; j += 2) begin
            if (s >= j * SPT && s < (j + 2) * SPT)
                return chip_seq[j] ? 16 + lut[s - j * SPT] : 16 - lut[s - j * SPT];
        end
        return 16;
    endfunction

    // mode: 0 = pret always 1, 1 = pret 1,0,1,0..., 2 = random pret.
    // abort_at >= 0 asserts reset while sample abort_at is on the outputs.
    task automatic run_burst(input int n, input int mode, input int abort_at, output int got);
        int          idx = 0;
        int          cyc = 0;
        bit          started = 0;
        bit          hold = 0;
        logic [W-1:0] hold_i = '0;
        logic [W-1:0] hold_q = '0;
        obs_i.delete();
        obs_q.delete();
        got = 0;
        while (cyc < 3000) begin
            @(negedge clk);
            if (hold) begin
                check("hold_i", i_out, hold_i);
                check("hold_q", q_out, hold_q);
                check("hold_valid", out_valid, 1);
            end
            if (out_valid) started = 1;
            if (started && !out_valid) break;
            if (abort_at >= 0 && out_valid && obs_i.size() == abort_at) begin
                resetn = 1'b0;
                #1;
                check("rst_mid_i", i_out, 16);
                check("rst_mid_q", q_out, 16);
                check("rst_mid_valid", out_valid, 0);
                check("rst_mid_busy", busy, 0);
                check("rst_mid_ready", chip_ready, 1);
                chip_valid = 1'b0;
                @(negedge clk);
                resetn = 1'b1;
                got = obs_i.size();
                return;
            end
            if (mode == 0)      pret = 1'b1;
            else if (mode == 1) pret = (cyc % 2 == 0);
            else                pret = 1'($urandom_range(0, 1));
            if (out_valid && pret) begin
                obs_i.push_back(int'(i_out));
                obs_q.push_back(int'(q_out));
            end
            hold   = out_valid && !pret;
            hold_i = i_out;
            hold_q = q_out;
            chip_valid = (idx < n);
            chip_in    = chip_seq[idx];
            chip_last  = (idx == n - 1);
            if (chip_valid && chip_ready) idx++;
            cyc++;
        end
        if (cyc >= 3000) fail_now("burst_timeout");
        chip_valid = 1'b0;
        chip_last  = 1'b0;
        got = obs_i.size();
    endtask

    task automatic compare_burst(input int id, input int n, input int exp_len, input int got, input bit use_ref);
        check($sformatf("b%0d_len", id), got, exp_len);
        for (int s = 0; s < got && s < (n + 1) * SPT; s++) begin
            check($sformatf("b%0d_i%0d", id, s), obs_i[s], model_sample(s, n, 0));
            check($sformatf("b%0d_q%0d", id, s), obs_q[s], model_sample(s, n, 1));
            if (use_ref && s < 12) begin
                check($sformatf("b%0d_ref_i%0d", id, s), obs_i[s], ref_i[s]);
                check($sformatf("b%0d_ref_q%0d", id, s), obs_q[s], ref_q[s]);
            end
        end
    endtask

    task automatic post_burst(input int id);
        check($sformatf("b%0d_busy", id), busy, 0);
        check($sformatf("b%0d_ready", id), chip_ready, 1);
        check($sformatf("b%0d_underrun", id), underrun, 0);
    endtask

    task automatic underrun_test();
        int w = 0;
        @(negedge clk);
        chip_valid = 1'b1;
        chip_in    = 1'b1;
        chip_last  = 1'b0;
        pret       = 1'b1;
        @(negedge clk);
        chip_valid = 1'b0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid) begin
            fail_now("ur_start");
            return;
        end
        for (int s = 0; s < 12; s++) begin
            check($sformatf("ur_i%0d", s), i_out, (s < 8) ? 16 + lut[s] : 16);
            check($sformatf("ur_q%0d", s), q_out, 16);
            check($sformatf("ur_flag%0d", s), underrun, (s >= 4) ? 1 : 0);
            if (s == 11) begin
                chip_valid = 1'b1;
                chip_in    = 1'b0;
                chip_last  = 1'b1;
                pret       = 1'b0;
            end
            @(negedge clk);
        end
        chip_valid = 1'b0;
        chip_last  = 1'b0;
        pret       = 1'b1;
        check("ur_held_valid", out_valid, 1);
        check("ur_buf_ready", chip_ready, 0);
        @(negedge clk);
        for (int s = 12; s < 20; s++) begin
            check($sformatf("ur_i%0d", s), i_out, 16);
            check($sformatf("ur_q%0d", s), q_out, 16 - lut[s - 12]);
            check($sformatf("ur_v%0d", s), out_valid, 1);
            @(negedge clk);
        end
        check("ur_end_valid", out_valid, 0);
        check("ur_end_busy", busy, 0);
        check("ur_end_flag", underrun, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int n;

        for (int k = 0; k < 2 * SPT; k++)
            lut[k] = int'(real'(AMP) * $sin(3.14159265358979 * real'(k) / real'(2 * SPT)));
        ref_i = '{16, 22, 27, 30, 31, 30, 27, 22, 16, 16, 16, 16};
        ref_q = '{16, 16, 16, 16, 16, 10, 5, 2, 1, 2, 5, 10};
        cases[0] = '{n: 2, bits: 8'h01, mode: 0, exp_len: 12, use_ref: 1};
        cases[1] = '{n: 2, bits: 8'h01, mode: 1, exp_len: 12, use_ref: 1};
        cases[2] = '{n: 1, bits: 8'h01, mode: 0, exp_len: 8,  use_ref: 0};
        cases[3] = '{n: 3, bits: 8'h03, mode: 2, exp_len: 16, use_ref: 0};
        cases[4] = '{n: 5, bits: 8'h16, mode: 2, exp_len: 24, use_ref: 0};

        // Reset
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_i", i_out, 16);
        check("rst_q", q_out, 16);
        check("rst_valid", out_valid, 0);
        check("rst_ready", chip_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
        resetn = 1'b1;

        // Directed table
        for (int c = 0; c < 5; c++) begin
            for (int j = 0; j < cases[c].n; j++) chip_seq[j] = cases[c].bits[j];
            run_burst(cases[c].n, cases[c].mode, -1, got);
            compare_burst(c, cases[c].n, cases[c].exp_len, got, cases[c].use_ref);
            post_burst(c);
        end

        // Random bursts with random backpressure
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 24);
            for (int j = 0; j < n; j++) chip_seq[j] = 1'($urandom_range(0, 1));
            run_burst(n, 2, -1, got);
            compare_burst(10 + r, n, (n + 1) * SPT, got, 0);
            post_burst(10 + r);
        end

        // Continuous 32-chip stream
        for (int j = 0; j < 32; j++) chip_seq[j] = 1'($urandom_range(0, 1));
        run_burst(32, 0, -1, got);
        compare_burst(20, 32, 132, got, 0);
        post_burst(20);

        // Underrun then late last chip
        underrun_test();

        // Reset during a burst, then the reference burst again
        chip_seq[0] = 1'b1;
        chip_seq[1] = 1'b0;
        run_burst(2, 0, 7, got);
        check("abort_len", got, 7);
        for (int s = 0; s < got && s < 12; s++) begin
            check($sformatf("abort_i%0d", s), obs_i[s], ref_i[s]);
            check($sformatf("abort_q%0d", s), obs_q[s], ref_q[s]);
        end
        run_burst(2, 0, -1, got);
        compare_burst(30, 2, 12, got, 1);
        post_burst(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
